// File: rtl/sprite_pkg.sv
// Shared types and sizing helpers for the sprite sheet loader and its renderer-side memories.
package sprite_pkg;

    localparam int COLOR_ID_WIDTH = 8;
    localparam int COLOR_WIDTH    = 24;
    localparam int PALETTE_DEPTH  = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAL,
        S_IMG,
        S_CHK,
        S_DONE,
        S_ERR
    } loader_state_e;

    // Degenerate one-entry images still need a one-bit address bus.
    function automatic int img_addr_width(input int sheets, input int w, input int h);
        return (sheets * w * h > 1) ? $clog2(sheets * w * h) : 1;
    endfunction

endpackage

// File: rtl/rgb_byte_assembler.sv
// Packs R, G, B bytes into one palette word and issues a registered single-cycle write with the entry index.
module rgb_byte_assembler
    import sprite_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      byte_valid_i,
    input  logic [7:0]                byte_i,
    output logic                      last_o,
    output logic                      word_valid_o,
    output logic [COLOR_ID_WIDTH-1:0] index_o,
    output logic [COLOR_WIDTH-1:0]    word_o
);

    localparam logic [COLOR_ID_WIDTH-1:0] LAST_ENTRY = COLOR_ID_WIDTH'(PALETTE_DEPTH - 1);

    logic [1:0]                phase_q, phase_d;
    logic [7:0]                red_q, red_d;
    logic [7:0]                green_q, green_d;
    logic [COLOR_ID_WIDTH-1:0] entry_q, entry_d;
    logic                      word_valid_q, word_valid_d;
    logic [COLOR_ID_WIDTH-1:0] index_q, index_d;
    logic [COLOR_WIDTH-1:0]    word_q, word_d;
    logic                      complete;

    // The blue byte of the final entry tells the parent FSM to move on to image data.
    assign complete = byte_valid_i && (phase_q == 2'd2);
    assign last_o   = complete && (entry_q == LAST_ENTRY);

    always_comb begin
        phase_d      = phase_q;
        red_d        = red_q;
        green_d      = green_q;
        entry_d      = entry_q;
        word_valid_d = 1'b0;
        index_d      = index_q;
        word_d       = word_q;
        if (clear_i) begin
            phase_d = 2'd0;
            entry_d = '0;
        end else if (byte_valid_i) begin
            case (phase_q)
                2'd0: begin
                    red_d   = byte_i;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    green_d = byte_i;
                    phase_d = 2'd2;
                end
                default: begin
                    word_valid_d = 1'b1;
                    word_d       = {red_q, green_q, byte_i};
                    index_d      = entry_q;
                    entry_d      = entry_q + COLOR_ID_WIDTH'(1);
                    phase_d      = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q      <= 2'd0;
            red_q        <= '0;
            green_q      <= '0;
            entry_q      <= '0;
            word_valid_q <= 1'b0;
            index_q      <= '0;
            word_q       <= '0;
        end else begin
            phase_q      <= phase_d;
            red_q        <= red_d;
            green_q      <= green_d;
            entry_q      <= entry_d;
            word_valid_q <= word_valid_d;
            index_q      <= index_d;
            word_q       <= word_d;
        end
    end

    assign word_valid_o = word_valid_q;
    assign index_o      = index_q;
    assign word_o       = word_q;

endmodule

// File: rtl/sprite_sheet_loader.sv
// Parses one framed upload (sync, 256 RGB palette entries, indexed image bytes, XOR checksum)
// and drives the palette and image BRAM write ports.
module sprite_sheet_loader
    import sprite_pkg::*;
#(
    parameter int         WIDTH       = 256,
    parameter int         HEIGHT      = 256,
    parameter int         SHEET_COUNT = 2,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                                                clk_in,
    input  logic                                                rst_n_in,
    input  logic [7:0]                                          byte_in,
    input  logic                                                byte_valid_in,
    output logic                                                byte_ready_out,
    input  logic                                                abort_in,
    output logic                                                pal_we_out,
    output logic [COLOR_ID_WIDTH-1:0]                           pal_addr_out,
    output logic [COLOR_WIDTH-1:0]                              pal_data_out,
    output logic                                                img_we_out,
    output logic [img_addr_width(SHEET_COUNT, WIDTH, HEIGHT)-1:0] img_addr_out,
    output logic [7:0]                                          img_data_out,
    output logic                                                busy_out,
    output logic                                                done_out,
    output logic                                                err_out
);

    localparam int IMG_DEPTH = SHEET_COUNT * WIDTH * HEIGHT;
    localparam int IMG_AW    = img_addr_width(SHEET_COUNT, WIDTH, HEIGHT);
    localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_DEPTH - 1);

    loader_state_e     state_q, state_d;
    logic [IMG_AW-1:0] img_cnt_q, img_cnt_d;
    logic              img_we_q, img_we_d;
    logic [IMG_AW-1:0] img_addr_q, img_addr_d;
    logic [7:0]        img_data_q, img_data_d;
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;

    logic accept;
    logic start_frame;
    logic pal_byte;
    logic pal_last;

    // Abort wins over a simultaneous handshake, so that byte is simply dropped.
    assign byte_ready_out = (state_q != S_DONE) && (state_q != S_ERR);
    assign accept         = byte_valid_in && byte_ready_out && !abort_in;
    assign start_frame    = accept && (state_q == S_IDLE) && (byte_in == SYNC_BYTE);
    assign pal_byte       = accept && (state_q == S_PAL);

    rgb_byte_assembler u_rgb_byte_assembler (
        .clk_i        (clk_in),
        .rst_ni       (rst_n_in),
        .clear_i      (start_frame || abort_in),
        .byte_valid_i (pal_byte),
        .byte_i       (byte_in),
        .last_o       (pal_last),
        .word_valid_o (pal_we_out),
        .index_o      (pal_addr_out),
        .word_o       (pal_data_out)
    );

    always_comb begin
        state_d = state_q;
        if (abort_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_frame) state_d = S_PAL;
                S_PAL:  if (pal_last) state_d = S_IMG;
                S_IMG:  if (accept && (img_cnt_q == IMG_LAST)) state_d = S_CHK;
                S_CHK:  if (accept) state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Image write port, running checksum and the sticky error flag.
    always_comb begin
        img_cnt_d  = img_cnt_q;
        img_we_d   = 1'b0;
        img_addr_d = img_addr_q;
        img_data_d = img_data_q;
        csum_d     = csum_q;
        err_d      = err_q;
        if (start_frame) begin
            img_cnt_d = '0;
            csum_d    = '0;
            err_d     = 1'b0;
        end
        if (pal_byte) begin
            csum_d = csum_q ^ byte_in;
        end
        if (accept && (state_q == S_IMG)) begin
            img_we_d   = 1'b1;
            img_addr_d = img_cnt_q;
            img_data_d = byte_in;
            img_cnt_d  = (img_cnt_q == IMG_LAST) ? '0 : img_cnt_q + IMG_AW'(1);
            csum_d     = csum_q ^ byte_in;
        end
        if (accept && (state_q == S_CHK) && (byte_in != csum_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            img_cnt_q  <= '0;
            img_we_q   <= 1'b0;
            img_addr_q <= '0;
            img_data_q <= '0;
            csum_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            img_cnt_q  <= img_cnt_d;
            img_we_q   <= img_we_d;
            img_addr_q <= img_addr_d;
            img_data_q <= img_data_d;
            csum_q     <= csum_d;
            err_q      <= err_d;
        end
    end

    assign img_we_out   = img_we_q;
    assign img_addr_out = img_addr_q;
    assign img_data_out = img_data_q;
    assign busy_out     = (state_q == S_PAL) || (state_q == S_IMG) || (state_q == S_CHK);
    assign done_out     = (state_q == S_DONE);
    assign err_out      = err_q;

endmodule

// File: tb/tb_sprite_sheet_loader.sv
// Scoreboard bench for sprite_sheet_loader on a 4x4x2 image, with behavioural palette/image BRAMs for readback.
module tb_sprite_sheet_loader;
    import sprite_pkg::*;

    localparam int W         = 4;
    localparam int H         = 4;
    localparam int SC        = 2;
    localparam int IMG_DEPTH = SC * W * H;
    localparam int IMG_AW    = 5;
    localparam int PAL_BYTES = 3 * PALETTE_DEPTH;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct packed {
        logic [23:0] data;
        logic [7:0]  addr;
    } pal_wr_t;

    typedef struct packed {
        logic [7:0]        data;
        logic [IMG_AW-1:0] addr;
    } img_wr_t;

    logic              clk = 1'b0;
    logic              rst_n_in;
    logic [7:0]        byte_in;
    logic              byte_valid_in;
    logic              byte_ready_out;
    logic              abort_in;
    logic              pal_we_out;
    logic [7:0]        pal_addr_out;
    logic [23:0]       pal_data_out;
    logic              img_we_out;
    logic [IMG_AW-1:0] img_addr_out;
    logic [7:0]        img_data_out;
    logic              busy_out;
    logic              done_out;
    logic              err_out;

    pal_wr_t expPal[$];
    pal_wr_t obsPal[$];
    img_wr_t expImg[$];
    img_wr_t obsImg[$];

    logic [23:0] palMem[PALETTE_DEPTH];
    logic [23:0] expPalMem[PALETTE_DEPTH];
    logic [7:0]  imgMem[IMG_DEPTH];
    logic [7:0]  expImgMem[IMG_DEPTH];

    int nChecks   = 0;
    int nFail     = 0;
    int doneCount = 0;
    int dualCount = 0;

    always #5 clk = ~clk;

    sprite_sheet_loader #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .SHEET_COUNT (SC),
        .SYNC_BYTE   (SYNC)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .byte_ready_out (byte_ready_out),
        .abort_in       (abort_in),
        .pal_we_out     (pal_we_out),
        .pal_addr_out   (pal_addr_out),
        .pal_data_out   (pal_data_out),
        .img_we_out     (img_we_out),
        .img_addr_out   (img_addr_out),
        .img_data_out   (img_data_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .err_out        (err_out)
    );

    // Renderer-side BRAMs written through the loader's ports.
    always @(posedge clk) begin
        if (pal_we_out) palMem[pal_addr_out] <= pal_data_out;
        if (img_we_out) imgMem[img_addr_out] <= img_data_out;
    end

    // Capture every strobe away from the active edge; tasks compare against the expected queues.
    always @(negedge clk) begin
        if (pal_we_out) obsPal.push_back({pal_data_out, pal_addr_out});
        if (img_we_out) obsImg.push_back({img_data_out, img_addr_out});
        if (done_out) doneCount++;
        if (pal_we_out && img_we_out) dualCount++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    function automatic logic [7:0] palByte(input int k, input logic [7:0] seed);
        return 8'(k * 29 + 7) ^ seed;
    endfunction

    function automatic logic [7:0] imgByte(input int j, input logic [7:0] seed);
        return 8'(j) + seed;
    endfunction

    task automatic clear_queues;
        expPal.delete();
        obsPal.delete();
        expImg.delete();
        obsImg.delete();
        dualCount = 0;
    endtask

    // Drives one byte from a negedge and returns on the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited;
        waited = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                byte_valid_in = 1'b0;
                byte_in       = 8'($urandom);
                @(negedge clk);
            end
        end
        byte_in       = b;
        byte_valid_in = 1'b1;
        while (!byte_ready_out && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        nChecks++;
        if (byte_ready_out !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL ready_timeout: byte_ready_out=%b, required 1 within 16 cycles", byte_ready_out);
        end
        @(negedge clk);
        byte_valid_in = 1'b0;
    endtask

    // Sends sync, palette, image and checksum (XOR'd with flip); stops early with abort at image index abortAt.
    task automatic send_frame(input logic [7:0] seed, input bit gaps, input logic [7:0] flip, input int abortAt);
        logic [7:0]  b;
        logic [7:0]  x;
        logic [23:0] ent;
        x   = 8'h00;
        ent = 24'h0;
        send_byte(SYNC, 1'b0);
        for (int k = 0; k < PAL_BYTES; k++) begin
            b   = palByte(k, seed);
            x   = x ^ b;
            ent = {ent[15:0], b};
            send_byte(b, 1'b0);
            if (k % 3 == 2) begin
                expPal.push_back({ent, 8'(k / 3)});
                expPalMem[k / 3] = ent;
            end
        end
        for (int j = 0; j < IMG_DEPTH; j++) begin
            b = imgByte(j, seed);
            if (j == abortAt) begin
                byte_in       = b;
                byte_valid_in = 1'b1;
                abort_in      = 1'b1;
                @(negedge clk);
                abort_in      = 1'b0;
                byte_valid_in = 1'b0;
                return;
            end
            x = x ^ b;
            send_byte(b, gaps);
            expImg.push_back({b, IMG_AW'(j)});
            expImgMem[j] = b;
        end
        send_byte(x ^ flip, 1'b0);
    endtask

    task automatic drain_scoreboard(input string name, input bit checkMem);
        pal_wr_t pe, po;
        img_wr_t ie, io;
        repeat (3) @(negedge clk);
        nChecks++;
        if (obsPal.size() != expPal.size()) begin
            nFail++;
            $display("[TB] FAIL %s pal_count: got %0d, required %0d", name, obsPal.size(), expPal.size());
        end
        while (expPal.size() > 0 && obsPal.size() > 0) begin
            pe = expPal.pop_front();
            po = obsPal.pop_front();
            nChecks++;
            if (po !== pe) begin
                nFail++;
                $display("[TB] FAIL %s pal_write: got addr %h data %h, required addr %h data %h",
                         name, po.addr, po.data, pe.addr, pe.data);
            end
        end
        nChecks++;
        if (obsImg.size() != expImg.size()) begin
            nFail++;
            $display("[TB] FAIL %s img_count: got %0d, required %0d", name, obsImg.size(), expImg.size());
        end
        while (expImg.size() > 0 && obsImg.size() > 0) begin
            ie = expImg.pop_front();
            io = obsImg.pop_front();
            nChecks++;
            if (io !== ie) begin
                nFail++;
                $display("[TB] FAIL %s img_write: got addr %h data %h, required addr %h data %h",
                         name, io.addr, io.data, ie.addr, ie.data);
            end
        end
        nChecks++;
        if (dualCount != 0) begin
            nFail++;
            $display("[TB] FAIL %s dual_strobe: got %0d cycles with both strobes, required 0", name, dualCount);
        end
        if (checkMem) begin
            for (int i = 0; i < PALETTE_DEPTH; i++) begin
                nChecks++;
                if (palMem[i] !== expPalMem[i]) begin
                    nFail++;
                    $display("[TB] FAIL %s pal_readback[%0d]: got %h, required %h", name, i, palMem[i], expPalMem[i]);
                end
            end
            for (int i = 0; i < IMG_DEPTH; i++) begin
                nChecks++;
                if (imgMem[i] !== expImgMem[i]) begin
                    nFail++;
                    $display("[TB] FAIL %s img_readback[%0d]: got %h, required %h", name, i, imgMem[i], expImgMem[i]);
                end
            end
        end
        clear_queues();
    endtask

    task automatic test_reset;
        rst_n_in      = 1'b0;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        abort_in      = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if ({pal_we_out, pal_addr_out, pal_data_out, img_we_out, img_addr_out, img_data_out,
             busy_out, done_out, err_out} !== '0 || byte_ready_out !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL reset_outputs: got we=%b/%b busy=%b done=%b err=%b ready=%b, required zeros and ready=1",
                     pal_we_out, img_we_out, busy_out, done_out, err_out, byte_ready_out);
        end
        rst_n_in = 1'b1;
        @(negedge clk);
        send_byte(SYNC, 1'b0);
        for (int k = 0; k < 10; k++) send_byte(8'(k + 1), 1'b0);
        nChecks++;
        if (busy_out !== 1'b1 || pal_addr_out !== 8'd2) begin
            nFail++;
            $display("[TB] FAIL midpal_state: got busy=%b pal_addr=%h, required busy=1 pal_addr=02", busy_out, pal_addr_out);
        end
        rst_n_in = 1'b0;
        #1;
        nChecks++;
        if ({pal_we_out, pal_addr_out, pal_data_out, img_we_out, img_addr_out, img_data_out,
             busy_out, done_out, err_out} !== '0 || byte_ready_out !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL midpal_reset: got pal_addr=%h pal_data=%h busy=%b ready=%b, required zeros and ready=1",
                     pal_addr_out, pal_data_out, busy_out, byte_ready_out);
        end
        @(negedge clk);
        rst_n_in = 1'b1;
        @(negedge clk);
        clear_queues();
        doneCount = 0;
        send_frame(8'h5A, 1'b0, 8'h00, -1);
        nChecks++;
        if (done_out !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL reload_done: got %b, required 1", done_out);
        end
        drain_scoreboard("reload", 1'b1);
        nChecks++;
        if (doneCount != 1) begin
            nFail++;
            $display("[TB] FAIL reload_done_count: got %0d, required 1", doneCount);
        end
    endtask

    task automatic test_presync;
        clear_queues();
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        nChecks++;
        if (busy_out !== 1'b0 || pal_we_out !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL presync_ignored: got busy=%b pal_we=%b, required 0/0", busy_out, pal_we_out);
        end
        send_byte(SYNC, 1'b0);
        nChecks++;
        if (busy_out !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL sync_busy: got %b, required 1", busy_out);
        end
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        nChecks++;
        if (pal_we_out !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL early_pal_we: got %b, required 0", pal_we_out);
        end
        send_byte(8'h56, 1'b0);
        nChecks++;
        if (pal_we_out !== 1'b1 || pal_addr_out !== 8'h00 || pal_data_out !== 24'h123456) begin
            nFail++;
            $display("[TB] FAIL entry0_write: got we=%b addr=%h data=%h, required 1/00/123456",
                     pal_we_out, pal_addr_out, pal_data_out);
        end
        @(negedge clk);
        nChecks++;
        if (pal_we_out !== 1'b0 || obsPal.size() != 1) begin
            nFail++;
            $display("[TB] FAIL entry0_single: got we=%b writes=%0d, required 0 and 1 write", pal_we_out, obsPal.size());
        end
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        clear_queues();
    endtask

    task automatic test_full_frame;
        doneCount = 0;
        send_frame(8'h00, 1'b0, 8'h00, -1);
        nChecks++;
        if (done_out !== 1'b1 || busy_out !== 1'b0 || byte_ready_out !== 1'b0 || err_out !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL full_done_cycle: got done=%b busy=%b ready=%b err=%b, required 1/0/0/0",
                     done_out, busy_out, byte_ready_out, err_out);
        end
        drain_scoreboard("full", 1'b1);
        nChecks++;
        if (doneCount != 1) begin
            nFail++;
            $display("[TB] FAIL full_done_count: got %0d, required 1", doneCount);
        end
    endtask

    task automatic test_bad_checksum;
        doneCount = 0;
        send_frame(8'h33, 1'b0, 8'h01, -1);
        nChecks++;
        if (err_out !== 1'b1 || done_out !== 1'b0 || busy_out !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL bad_csum_err: got err=%b done=%b busy=%b, required 1/0/0", err_out, done_out, busy_out);
        end
        drain_scoreboard("bad_csum", 1'b1);
        nChecks++;
        if (err_out !== 1'b1 || doneCount != 0) begin
            nFail++;
            $display("[TB] FAIL bad_csum_sticky: got err=%b done_count=%0d, required 1/0", err_out, doneCount);
        end
        send_byte(SYNC, 1'b0);
        nChecks++;
        if (err_out !== 1'b0 || busy_out !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL sync_clears_err: got err=%b busy=%b, required 0/1", err_out, busy_out);
        end
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        clear_queues();
    endtask

    task automatic test_random_valid;
        doneCount = 0;
        send_frame(8'h3C, 1'b1, 8'h00, -1);
        nChecks++;
        if (done_out !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL random_done: got %b, required 1", done_out);
        end
        drain_scoreboard("random_valid", 1'b1);
        nChecks++;
        if (doneCount != 1) begin
            nFail++;
            $display("[TB] FAIL random_done_count: got %0d, required 1", doneCount);
        end
    endtask

    task automatic test_abort;
        doneCount = 0;
        send_frame(8'hC3, 1'b0, 8'h00, 5);
        nChecks++;
        if (busy_out !== 1'b0 || img_we_out !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL abort_next_cycle: got busy=%b img_we=%b, required 0/0", busy_out, img_we_out);
        end
        repeat (5) @(negedge clk);
        nChecks++;
        if (doneCount != 0 || err_out !== 1'b0 || busy_out !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL abort_quiet: got done_count=%0d err=%b busy=%b, required 0/0/0",
                     doneCount, err_out, busy_out);
        end
        drain_scoreboard("abort", 1'b0);
        doneCount = 0;
        send_frame(8'h77, 1'b0, 8'h00, -1);
        nChecks++;
        if (done_out !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL after_abort_done: got %b, required 1", done_out);
        end
        drain_scoreboard("after_abort", 1'b1);
        nChecks++;
        if (doneCount != 1) begin
            nFail++;
            $display("[TB] FAIL after_abort_done_count: got %0d, required 1", doneCount);
        end
    endtask

    initial begin
        test_reset();
        test_presync();
        test_full_frame();
        test_bad_checksum();
        test_random_valid();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
